// File: rtl/parallel_serializer.sv
// rtl/parallel_serializer.sv - parallel-in / serial-out frame unloader, PI[M-1] emitted first
module parallel_serializer #(
    parameter int M = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] PI [0:M-1],
    output logic [7:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_done,
    output logic       busy
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_d;
    logic [7:0]      frame_buf [0:M-1];
    logic            capture;
    logic            done_d;

    assign busy = (state == BUSY);

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        capture    = 1'b0;
        done_d     = 1'b0;
        out_valid  = 1'b0;
        data_out   = 8'h00;
        out_last   = 1'b0;
        load_ready = 1'b1;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    capture = 1'b1;
                    idx_d   = IW'(M - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_valid  = 1'b1;
                data_out   = frame_buf[idx];
                out_last   = (idx == '0);
                // A new frame may only land on the accepted final beat, giving zero-bubble frames.
                load_ready = out_last && out_ready;
                if (out_ready) begin
                    if (!out_last) begin
                        idx_d = idx - IW'(1);
                    end else begin
                        done_d = 1'b1;
                        if (load_valid) begin
                            capture = 1'b1;
                            idx_d   = IW'(M - 1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < M; i++) begin
                frame_buf[i] <= 8'h00;
            end
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            frame_done <= done_d;
            if (capture) begin
                for (int i = 0; i < M; i++) begin
                    frame_buf[i] <= PI[i];
                end
            end
        end
    end

endmodule
